// File: rtl/alu_operand_sequencer.sv
// alu_operand_sequencer: debounced operand entry A then B/cin for the adder, with a held result register.
// Defining ACCUM_CHAIN_EN makes a press in SHOW chain the result into op_a and go to LOAD_B.
module alu_operand_sequencer #(
   parameter int WIDTH     = 8,
   parameter int DB_CYCLES = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] sw_in,
   input  logic             sw_cin,
   input  logic             btn_store,
   output logic [WIDTH-1:0] op_a,
   output logic [WIDTH-1:0] op_b,
   output logic             cin,
   input  logic [WIDTH-1:0] sum_in,
   input  logic             cout_in,
   output logic [WIDTH-1:0] result,
   output logic             result_cout,
   output logic             result_valid,
   output logic [1:0]       state_led
);
   localparam int CW = $clog2(DB_CYCLES + 1);
   typedef enum logic [1:0] {LOAD_A = 2'b00, LOAD_B = 2'b01, ADD = 2'b10, SHOW = 2'b11} state_t;
   state_t         state;
   logic           sync1, sync2, db_level, db_prev;
   logic [CW-1:0]  cnt;
   logic           store_pulse;
   // Counter runs only while the synced level disagrees with the debounced one.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync1    <= 1'b0;
         sync2    <= 1'b0;
         db_level <= 1'b0;
         db_prev  <= 1'b0;
         cnt      <= '0;
      end else begin
         sync1   <= btn_store;
         sync2   <= sync1;
         db_prev <= db_level;
         if (sync2 == db_level) cnt <= '0;
         else if (cnt == CW'(DB_CYCLES - 1)) begin
            db_level <= sync2;
            cnt      <= '0;
         end else cnt <= cnt + 1'b1;
      end
   end
   assign store_pulse = db_level & ~db_prev;
   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= LOAD_A;
         op_a         <= '0;
         op_b         <= '0;
         cin          <= 1'b0;
         result       <= '0;
         result_cout  <= 1'b0;
         result_valid <= 1'b0;
      end else begin
         case (state)
            LOAD_A: if (store_pulse) begin
               op_a  <= sw_in;
               state <= LOAD_B;
            end
            LOAD_B: if (store_pulse) begin
               op_b  <= sw_in;
               cin   <= sw_cin;
               state <= ADD;
            end
            ADD: begin
               result       <= sum_in;
               result_cout  <= cout_in;
               result_valid <= 1'b1;
               state        <= SHOW;
            end
            default: if (store_pulse) begin
               result_valid <= 1'b0;
`ifdef ACCUM_CHAIN_EN
               op_a  <= result;
               state <= LOAD_B;
`else
               state <= LOAD_A;
`endif
            end
         endcase
      end
   end
   assign state_led = state;
endmodule

// File: tb/tb_alu_operand_sequencer.sv
// tb_alu_operand_sequencer: directed checks of debounce, operand sequencing and result hold.
module tb_alu_operand_sequencer;
   localparam int DB = 16;
   logic       clk = 1'b0, rst = 1'b1, sw_cin = 1'b0, btn_store = 1'b0, cin, cout_in, result_cout, result_valid;
   logic [7:0] sw_in = 8'h00, op_a, op_b, sum_in, result;
   logic [1:0] state_led;
   int         checks = 0, failures = 0;
   bit         found;
   alu_operand_sequencer #(.WIDTH(8), .DB_CYCLES(DB)) dut (
      .clk(clk), .rst(rst), .sw_in(sw_in), .sw_cin(sw_cin), .btn_store(btn_store),
      .op_a(op_a), .op_b(op_b), .cin(cin), .sum_in(sum_in), .cout_in(cout_in),
      .result(result), .result_cout(result_cout), .result_valid(result_valid), .state_led(state_led)
   );
   // Reference adder standing in for the Sklansky datapath.
   assign {cout_in, sum_in} = {1'b0, op_a} + {1'b0, op_b} + {8'b0, cin};
   always #5 clk = ~clk;
   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      btn_store = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
   endtask
   task automatic press(input logic [7:0] v, input logic c, input int hold);
      @(negedge clk);
      sw_in = v;
      sw_cin = c;
      btn_store = 1'b1;
      repeat (hold) @(negedge clk);
      btn_store = 1'b0;
      repeat (DB + 8) @(negedge clk);
   endtask
   task automatic test_reset();
      @(negedge clk);
      rst = 1'b1;
      btn_store = 1'b1;
      sw_in = 8'hA5;
      repeat (3) @(negedge clk);
      checks++;
      if ({op_a, op_b, cin, result, result_cout, result_valid, state_led} !== 28'h0) begin
         failures++;
         $display("FAIL reset_outputs got=%h required=0", {op_a, op_b, cin, result, result_cout, result_valid, state_led});
      end
      rst = 1'b0;
      repeat (DB + 2) @(posedge clk);
      @(negedge clk);
      checks++;
      if (op_a !== 8'h00 || state_led !== 2'b00) begin
         failures++;
         $display("FAIL reset_early_pulse op_a=%h state=%b required op_a=00 state=00", op_a, state_led);
      end
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (op_a !== 8'hA5 || state_led !== 2'b01) begin
         failures++;
         $display("FAIL reset_held_pulse op_a=%h state=%b required op_a=a5 state=01", op_a, state_led);
      end
      btn_store = 1'b0;
      repeat (DB + 8) @(negedge clk);
   endtask
   task automatic test_bounce();
      do_reset();
      sw_in = 8'h3C;
      found = 1'b0;
      for (int i = 0; i < 60; i++) begin
         if (i % 5 == 0) btn_store = ~btn_store;
         @(negedge clk);
         if (state_led !== 2'b00) found = 1'b1;
      end
      checks++;
      if (found) begin
         failures++;
         $display("FAIL bounce_reject state left 00 during bouncing, final=%b", state_led);
      end
      btn_store = 1'b1;
      repeat (DB + 10) @(negedge clk);
      checks++;
      if (op_a !== 8'h3C || state_led !== 2'b01) begin
         failures++;
         $display("FAIL bounce_stable op_a=%h state=%b required op_a=3c state=01", op_a, state_led);
      end
      repeat (100) @(negedge clk);
      checks++;
      if (state_led !== 2'b01) begin
         failures++;
         $display("FAIL bounce_single_pulse state=%b required 01", state_led);
      end
      btn_store = 1'b0;
      repeat (DB + 8) @(negedge clk);
   endtask
   task automatic test_basic_add();
      do_reset();
      press(8'h25, 1'b0, DB + 8);
      sw_in = 8'h1A;
      sw_cin = 1'b0;
      btn_store = 1'b1;
      found = 1'b0;
      for (int i = 0; i < 60 && !found; i++) begin
         @(negedge clk);
         if (state_led === 2'b10) found = 1'b1;
      end
      checks++;
      if (!found || op_b !== 8'h1A || result_valid !== 1'b0) begin
         failures++;
         $display("FAIL add_capture_b found=%0d op_b=%h valid=%b required found=1 op_b=1a valid=0", found, op_b, result_valid);
      end
      @(negedge clk);
      checks++;
      if (result !== 8'h3F || result_cout !== 1'b0 || result_valid !== 1'b1 || state_led !== 2'b11) begin
         failures++;
         $display("FAIL add_result result=%h cout=%b valid=%b state=%b required 3f 0 1 11", result, result_cout, result_valid, state_led);
      end
      btn_store = 1'b0;
      repeat (DB + 8) @(negedge clk);
   endtask
   task automatic test_overflow();
      do_reset();
      press(8'hFF, 1'b0, DB + 8);
      press(8'h01, 1'b1, DB + 8);
      checks++;
      if (result !== 8'h01 || result_cout !== 1'b1 || result_valid !== 1'b1 || state_led !== 2'b11) begin
         failures++;
         $display("FAIL overflow_result result=%h cout=%b valid=%b state=%b required 01 1 1 11", result, result_cout, result_valid, state_led);
      end
      press(8'h77, 1'b0, DB + 8);
`ifdef ACCUM_CHAIN_EN
      checks++;
      if (result_valid !== 1'b0 || state_led !== 2'b01 || op_a !== 8'h01) begin
         failures++;
         $display("FAIL overflow_clear valid=%b state=%b op_a=%h required 0 01 01", result_valid, state_led, op_a);
      end
`else
      checks++;
      if (result_valid !== 1'b0 || state_led !== 2'b00 || result !== 8'h01) begin
         failures++;
         $display("FAIL overflow_clear valid=%b state=%b result=%h required 0 00 01", result_valid, state_led, result);
      end
`endif
   endtask
   task automatic test_switch_isolation();
      do_reset();
      sw_in = 8'h11;
      btn_store = 1'b1;
      repeat (DB + 10) @(negedge clk);
      sw_in = 8'h99;
      sw_cin = 1'b1;
      repeat (190) @(negedge clk);
      checks++;
      if (op_a !== 8'h11 || state_led !== 2'b01) begin
         failures++;
         $display("FAIL iso_hold_a op_a=%h state=%b required 11 01", op_a, state_led);
      end
      btn_store = 1'b0;
      repeat (DB + 8) @(negedge clk);
      sw_in = 8'h22;
      sw_cin = 1'b0;
      btn_store = 1'b1;
      repeat (DB + 10) @(negedge clk);
      sw_in = 8'hEE;
      sw_cin = 1'b1;
      repeat (190) @(negedge clk);
      checks++;
      if (op_a !== 8'h11 || op_b !== 8'h22 || cin !== 1'b0 || result !== 8'h33 || state_led !== 2'b11) begin
         failures++;
         $display("FAIL iso_hold_b op_a=%h op_b=%h cin=%b result=%h state=%b required 11 22 0 33 11", op_a, op_b, cin, result, state_led);
      end
      btn_store = 1'b0;
      repeat (DB + 8) @(negedge clk);
   endtask
   task automatic test_show_press();
      do_reset();
      press(8'h10, 1'b0, DB + 8);
      press(8'h05, 1'b0, DB + 8);
      checks++;
      if (result !== 8'h15 || result_valid !== 1'b1) begin
         failures++;
         $display("FAIL chain_first result=%h valid=%b required 15 1", result, result_valid);
      end
      press(8'h05, 1'b0, DB + 8);
`ifdef ACCUM_CHAIN_EN
      checks++;
      if (state_led !== 2'b01 || op_a !== 8'h15 || result_valid !== 1'b0) begin
         failures++;
         $display("FAIL chain_reload state=%b op_a=%h valid=%b required 01 15 0", state_led, op_a, result_valid);
      end
      press(8'h05, 1'b0, DB + 8);
      checks++;
      if (result !== 8'h1A || result_valid !== 1'b1) begin
         failures++;
         $display("FAIL chain_second result=%h valid=%b required 1a 1", result, result_valid);
      end
`else
      checks++;
      if (state_led !== 2'b00 || op_a !== 8'h10 || result_valid !== 1'b0) begin
         failures++;
         $display("FAIL show_return state=%b op_a=%h valid=%b required 00 10 0", state_led, op_a, result_valid);
      end
      press(8'h05, 1'b0, DB + 8);
      checks++;
      if (op_a !== 8'h05 || state_led !== 2'b01 || result !== 8'h15) begin
         failures++;
         $display("FAIL show_reload_a op_a=%h state=%b result=%h required 05 01 15", op_a, state_led, result);
      end
`endif
   endtask
   task automatic test_reset_mid();
      press(8'h40, 1'b0, DB + 8);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      checks++;
      if ({op_a, op_b, cin, result, result_cout, result_valid, state_led} !== 28'h0) begin
         failures++;
         $display("FAIL reset_mid got=%h required=0", {op_a, op_b, cin, result, result_cout, result_valid, state_led});
      end
   endtask
   initial begin
      test_reset();
      test_bounce();
      test_basic_add();
      test_overflow();
      test_switch_isolation();
      test_show_press();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
